req_arb8: RTL
=============

Name: req_arb8

Overview:
- 8-requester arbiter that shares one downstream resource, such as the encoded-select datapath, among eight clients.
- Selects a winner by priority. Bit 7 is the highest priority in fixed mode.
- Holds the grant until the owner releases it or the hold limit expires, then re-arbitrates.
- Sits between the client request lines and the shared resource. Drives a one-hot grant and a 3-bit encoded owner ID.

Parameters:
- MAX_HOLD, 15, maximum consecutive GRANT cycles for one owner before forced release (legal range 1..255).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  arbiter enable; low forces release and IDLE.
- req  input  8  request vector; bit i high = client i wants the resource.
- gnt  output  8  one-hot grant, registered.
- gnt_id  output  3  encoded index of current owner, registered.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Behaviour:
- Reset (rst_n low, async): state=IDLE, gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0, hold_cnt=0, mask=8'h00.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If en=1 and (req & ~mask) != 0: winner = highest set bit of (req & ~mask).
  - Next edge: gnt=1<<winner, gnt_id=winner, gnt_valid=1, hold_cnt=0, mask cleared, go to GRANT.
  - Latency is 1 cycle, req to gnt.
- IDLE, masked case: if req != 0 but (req & ~mask) == 0, the masked client is the only requester. Clear mask and grant it next arbitration; there is no starvation lockout.
- GRANT, each cycle:
  - If en=0: clear gnt/gnt_id/gnt_valid next edge, hold_cnt=0, mask=0, go to IDLE.
  - Else if req[gnt_id]=0: normal release. Clear grant next edge, go to TURN.
  - Else if hold_cnt == MAX_HOLD-1: forced release. timeout=1 for the next cycle only, clear grant, mask=1<<gnt_id, go to TURN.
  - Else: hold_cnt increments. Grant is unchanged; other request changes are ignored (no pre-emption).
- TURN:
  - Exactly one cycle with gnt=0 (bus turnaround), then go to IDLE.
  - Arbitration happens in IDLE, so minimum owner-to-owner gap is 2 cycles of gnt=0.
- gnt_id holds 0 whenever gnt=0.
- Grant and timeout invariants:
  - gnt is always zero or one-hot. It never changes owner without passing through gnt=0.
  - timeout is never high in the same cycle as a new grant.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. With req held, timeout pulses on every release.
- en deasserted mid-grant has priority over release and timeout. No timeout pulse is produced.
- Async reset mid-grant: outputs drop immediately (not at the clock edge). Resume from IDLE after rst_n rises.

Optional Feature:
- Macro: REQ_ARB8_ROUND_ROBIN_EN.
- Defined:
  - Priority rotates. A last_id register (reset 3'd0) records each winner.
  - Next arbitration searches downward starting at (last_id-1) mod 8 and wraps 0->7; the first set bit in (req & ~mask) wins.
  - Masking rules are unchanged.
- Undefined: fixed priority, bit 7 highest, bit 0 lowest; no last_id register is built.

Test Plan:
- Reset/priority: rst_n low, then req=8'b0010_0101, en=1 -> one cycle later gnt=8'b0010_0000, gnt_id=5, gnt_valid=1.
- Release and turnaround:
  - Stimulus: client 5 drops req after 3 grant cycles while req[2] stays high.
  - Response: gnt=0 for 2 cycles, then gnt=8'b0000_0100, gnt_id=2.
- Timeout, MAX_HOLD=4:
  - Stimulus: req=8'h80 and req[0] held.
  - Response: gnt=8'h80 for exactly 4 cycles, then timeout=1 for 1 cycle; after turnaround gnt=8'h01, gnt_id=0 (client 7 masked).
- Sole masked requester: MAX_HOLD=4, req=8'h80 only -> grant 4 cycles, timeout pulse, 2 idle cycles, grant 8'h80 again.
- en/reset mid-grant:
  - en=0 during grant -> gnt=0 next edge, no timeout.
  - rst_n low mid-cycle -> gnt=0 immediately, before next clk edge.
- Round-robin (REQ_ARB8_ROUND_ROBIN_EN defined): req=8'hFF, each owner releases after 1 cycle -> gnt_id sequence 7,6,5,4,3,2,1,0,7.

Source files
------------

// File: rtl/req_arb8.sv
// req_arb8: 8-client arbiter with hold limit, turnaround and forced release.
// Optional rotating priority: define REQ_ARB8_ROUND_ROBIN_EN.
module req_arb8 #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_n;
    logic [7:0]       gnt_q, gnt_n;
    logic [2:0]       id_q, id_n;
    logic             to_q, to_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [7:0]       mask_q, mask_n;
    logic [7:0]       cand;
    logic [2:0]       win;

    // Candidates: unmasked requests, or the masked sole requester.
    always_comb begin
        cand = req & ~mask_q;
        if (cand == 8'h00) begin
            cand = req;
        end
    end

`ifdef REQ_ARB8_ROUND_ROBIN_EN
    logic [2:0] last_q, last_n;
    logic [2:0] idx;
    logic       found;

    // Rotating search downward from the slot below the last winner.
    always_comb begin
        win   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = last_q - 3'd1 - 3'(i);
            if (!found && cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
`else
    // Fixed priority: the highest set bit wins.
    always_comb begin
        win = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cand[i]) begin
                win = 3'(i);
            end
        end
    end
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        id_n    = id_q;
        to_n    = 1'b0;
        cnt_n   = cnt_q;
        mask_n  = mask_q;
`ifdef REQ_ARB8_ROUND_ROBIN_EN
        last_n  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (en && (req != 8'h00)) begin
                    gnt_n   = 8'd1 << win;
                    id_n    = win;
                    cnt_n   = '0;
                    mask_n  = 8'h00;
                    state_n = GRANT;
`ifdef REQ_ARB8_ROUND_ROBIN_EN
                    last_n  = win;
`endif
                end
            end
            GRANT: begin
                if (!en) begin
                    gnt_n   = 8'h00;
                    id_n    = 3'd0;
                    cnt_n   = '0;
                    mask_n  = 8'h00;
                    state_n = IDLE;
                end else if (!req[id_q]) begin
                    gnt_n   = 8'h00;
                    id_n    = 3'd0;
                    cnt_n   = '0;
                    state_n = TURN;
                end else if (cnt_q == HOLD_LAST) begin
                    to_n    = 1'b1;
                    gnt_n   = 8'h00;
                    id_n    = 3'd0;
                    cnt_n   = '0;
                    mask_n  = gnt_q;
                    state_n = TURN;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            TURN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 8'h00;
                id_n    = 3'd0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            id_q    <= 3'd0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= 8'h00;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            id_q    <= id_n;
            to_q    <= to_n;
            cnt_q   <= cnt_n;
            mask_q  <= mask_n;
        end
    end

`ifdef REQ_ARB8_ROUND_ROBIN_EN
    // Last winner, seeds the rotating search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 3'd0;
        end else begin
            last_q <= last_n;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = to_q;

endmodule
